// File: rtl/mmcm_drp_ctrl_if.sv
// Bundle between the DRP sequencer, its entry source and the primitive's
// DRP port.
//
// Handshake (entry stream): an entry transfers on every rising clk edge where
// s_valid && s_ready are both high. The source holds s_addr/s_mask/s_data/s_last
// stable while s_valid is high and s_ready is low. s_ready never depends on
// s_valid.
//
// DRP side: drp_en is a single-cycle strobe with drp_addr/drp_we/drp_di valid
// in that cycle; the primitive answers with a drp_rdy pulse (drp_do valid with
// it for reads). Only one access is outstanding at any time.
interface mmcm_drp_ctrl_if;
  logic        s_valid;
  logic        s_ready;
  logic [6:0]  s_addr;
  logic [15:0] s_mask;
  logic [15:0] s_data;
  logic        s_last;

  logic [6:0]  drp_addr;
  logic [15:0] drp_di;
  logic        drp_en;
  logic        drp_we;
  logic [15:0] drp_do;
  logic        drp_rdy;

  // Sequencer view
  modport slave (
    input  s_valid, s_addr, s_mask, s_data, s_last, drp_do, drp_rdy,
    output s_ready, drp_addr, drp_di, drp_en, drp_we
  );

  // Entry source plus primitive view
  modport master (
    output s_valid, s_addr, s_mask, s_data, s_last, drp_do, drp_rdy,
    input  s_ready, drp_addr, drp_di, drp_en, drp_we
  );
endinterface

// File: rtl/mmcm_drp_ctrl.sv
// mmcm_drp_ctrl: dynamic reconfiguration sequencer for an MMCME2/PLLE2.
// Holds the primitive in reset, applies a read-modify-write per entry
// (new = (old & mask) | (data & ~mask)), releases reset and waits for LOCKED.
// Optional feature macro: MMCM_DRP_READBACK_EN adds a read-back verify of
// every write (mismatch reports err_code 2'b11).
// state_dbg exposes the FSM state encoding for observation.
module mmcm_drp_ctrl #(
  parameter int DRDY_TIMEOUT = 255,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int RST_CYCLES   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mmcm_drp_ctrl_if.slave        bus,
  output logic                  mmcm_rst,
  input  logic                  locked,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            err_code,
  output logic [3:0]            state_dbg
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRDY_LAST = CNT_W'(DRDY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);

  localparam logic [1:0] CODE_DRDY = 2'b01;
  localparam logic [1:0] CODE_LOCK = 2'b10;
`ifdef MMCM_DRP_READBACK_EN
  localparam logic [1:0] CODE_VFY  = 2'b11;
`endif

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_RST_HOLD  = 4'd1,
    S_RD        = 4'd2,
    S_RD_WAIT   = 4'd3,
    S_WR        = 4'd4,
    S_WR_WAIT   = 4'd5,
    S_GET       = 4'd6,
    S_RELEASE   = 4'd7,
    S_LOCK_WAIT = 4'd8,
    S_FLUSH     = 4'd9
`ifdef MMCM_DRP_READBACK_EN
    ,
    S_VERIFY    = 4'd10,
    S_VFY_WAIT  = 4'd11
`endif
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [6:0]         addr_q, addr_d;
  logic [15:0]        mask_q, mask_d;
  logic [15:0]        data_q, data_d;
  logic               last_q, last_d;
  logic [15:0]        di_q, di_d;
  logic               rst_q, rst_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [1:0]         code_q, code_d;
  logic               meta_q, meta_d;
  logic               lock_s_q, lock_s_d;

  logic               s_ready_w;
  logic               accept;
  logic               drp_fail;
  logic [1:0]         fail_code;
  logic [15:0]        wr_val;

  // Entry-side ready and combinational DRP strobes decoded from the current state
  always_comb begin
    s_ready_w    = rst_n && ((state_q == S_IDLE) || (state_q == S_GET) ||
                             (state_q == S_FLUSH));
    bus.s_ready  = s_ready_w;
    bus.drp_en   = (state_q == S_RD) || (state_q == S_WR)
`ifdef MMCM_DRP_READBACK_EN
                   || (state_q == S_VERIFY)
`endif
                   ;
    bus.drp_we   = (state_q == S_WR);
    bus.drp_addr = addr_q;
    bus.drp_di   = di_q;
    busy         = (state_q != S_IDLE);
    mmcm_rst     = rst_q;
    done         = done_q;
    err          = err_q;
    err_code     = code_q;
    state_dbg    = state_q;
  end

  assign accept = bus.s_valid && s_ready_w;
  assign wr_val = (bus.drp_do & mask_q) | (data_q & ~mask_q);

  // Next-state, entry latching, shared timeout counter and pulse generation
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    mask_d    = mask_q;
    data_d    = data_q;
    last_d    = last_q;
    di_d      = di_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    code_d    = code_q;
    meta_d    = locked;
    lock_s_d  = meta_q;
    drp_fail  = 1'b0;
    fail_code = CODE_DRDY;
    rst_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d  = bus.s_addr;
          mask_d  = bus.s_mask;
          data_d  = bus.s_data;
          last_d  = bus.s_last;
          cnt_d   = '0;
          state_d = S_RST_HOLD;
        end
      end
      S_RST_HOLD: begin
        if (cnt_q == RST_LAST) state_d = S_RD;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      S_RD: begin
        cnt_d   = '0;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (bus.drp_rdy) begin
          di_d    = wr_val;
          state_d = S_WR;
        end else if (cnt_q == DRDY_LAST) begin
          drp_fail = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WR: begin
        cnt_d   = '0;
        state_d = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        if (bus.drp_rdy) begin
`ifdef MMCM_DRP_READBACK_EN
          state_d = S_VERIFY;
`else
          state_d = last_q ? S_RELEASE : S_GET;
`endif
        end else if (cnt_q == DRDY_LAST) begin
          drp_fail = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef MMCM_DRP_READBACK_EN
      S_VERIFY: begin
        cnt_d   = '0;
        state_d = S_VFY_WAIT;
      end
      S_VFY_WAIT: begin
        if (bus.drp_rdy) begin
          if (bus.drp_do != di_q) begin
            drp_fail  = 1'b1;
            fail_code = CODE_VFY;
          end else begin
            state_d = last_q ? S_RELEASE : S_GET;
          end
        end else if (cnt_q == DRDY_LAST) begin
          drp_fail = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      S_GET: begin
        if (accept) begin
          addr_d  = bus.s_addr;
          mask_d  = bus.s_mask;
          data_d  = bus.s_data;
          last_d  = bus.s_last;
          state_d = S_RD;
        end
      end
      S_RELEASE: begin
        cnt_d   = '0;
        state_d = S_LOCK_WAIT;
      end
      S_LOCK_WAIT: begin
        if (lock_s_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_q == LOCK_LAST) begin
          err_d   = 1'b1;
          code_d  = CODE_LOCK;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FLUSH: begin
        if (accept && bus.s_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A failed DRP access abandons the reconfiguration; remaining entries of
    // the stream are drained in FLUSH so the source stays in step.
    if (drp_fail) begin
      err_d   = 1'b1;
      code_d  = fail_code;
      state_d = last_q ? S_IDLE : S_FLUSH;
    end

    // Registered from the next state so RST is glitch-free across the
    // RD/WR/GET sequence.
    case (state_d)
      S_RST_HOLD, S_RD, S_RD_WAIT, S_WR, S_WR_WAIT, S_GET: rst_d = 1'b1;
`ifdef MMCM_DRP_READBACK_EN
      S_VERIFY, S_VFY_WAIT: rst_d = 1'b1;
`endif
      default: rst_d = 1'b0;
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      mask_q   <= '0;
      data_q   <= '0;
      last_q   <= 1'b0;
      di_q     <= '0;
      rst_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= 2'b00;
      meta_q   <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      mask_q   <= mask_d;
      data_q   <= data_d;
      last_q   <= last_d;
      di_q     <= di_d;
      rst_q    <= rst_d;
      done_q   <= done_d;
      err_q    <= err_d;
      code_q   <= code_d;
      meta_q   <= meta_d;
      lock_s_q <= lock_s_d;
    end
  end

endmodule

// File: tb/tb_mmcm_drp_ctrl.sv
// Testbench for mmcm_drp_ctrl: table of single-entry reconfigurations plus
// directed sequences for gapped streams, DRDY timeout/flush, lock timeout,
// mid-sequence reset and (with MMCM_DRP_READBACK_EN) read-back mismatch.
module tb_mmcm_drp_ctrl;

  localparam int DRDY_TIMEOUT = 255;
  localparam int LOCK_TIMEOUT = 65535;
`ifdef MMCM_DRP_READBACK_EN
  localparam int DEN_PER_ENTRY = 3;
`else
  localparam int DEN_PER_ENTRY = 2;
`endif
  localparam int W = 24;

  typedef struct {
    logic [6:0]  addr;
    logic [15:0] mask;
    logic [15:0] data;
    logic [15:0] do_val;
    logic [15:0] exp_di;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       mmcm_rst;
  logic       locked;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] err_code;
  logic [3:0] state_dbg;

  mmcm_drp_ctrl_if bus();

  mmcm_drp_ctrl #(
    .DRDY_TIMEOUT (DRDY_TIMEOUT),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .RST_CYCLES   (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .mmcm_rst  (mmcm_rst),
    .locked    (locked),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_code  (err_code),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset block ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #950000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] act_q[$];

  // DRP primitive model
  logic [15:0] mem [128];
  int          den_seq = 0;
  int          withhold_idx = -1;
  bit          corrupt = 1'b0;
  bit          pend = 1'b0;
  logic [15:0] pend_do = '0;

  // Monitor bookkeeping (updated on the falling edge)
  int   mon_cyc = 0;
  int   done_cnt, err_cnt, both_cnt = 0;
  int   rise_cnt, fall_cnt, rise_cyc, fall_cyc;
  int   first_den_cyc, last_den_cyc, den_cnt_mon, err_cyc;
  logic [1:0] last_code;
  logic rst_at_err;
  logic prev_rst = 1'b0;

  // Primitive DRP responder: DRDY one cycle after the DEN cycle
  initial begin
    bus.drp_rdy = 1'b0;
    bus.drp_do  = '0;
    forever begin
      @(posedge clk); #1;
      bus.drp_rdy = 1'b0;
      if (pend) begin
        bus.drp_rdy = 1'b1;
        bus.drp_do  = pend_do;
        pend        = 1'b0;
      end
      if (bus.drp_en === 1'b1) begin
        if (bus.drp_we) mem[bus.drp_addr] = bus.drp_di;
        if (den_seq != withhold_idx) begin
          pend    = 1'b1;
          pend_do = bus.drp_we ? 16'h0000 : (mem[bus.drp_addr] ^ {15'd0, corrupt});
        end
        den_seq++;
      end
    end
  end

  // Output monitor
  initial forever begin
    @(negedge clk);
    mon_cyc++;
    if (bus.drp_en === 1'b1) begin
      act_q.push_back({bus.drp_we, bus.drp_addr, bus.drp_we ? bus.drp_di : 16'h0000});
      if (first_den_cyc < 0) first_den_cyc = mon_cyc;
      last_den_cyc = mon_cyc;
      den_cnt_mon++;
    end
    if (mmcm_rst === 1'b1 && prev_rst === 1'b0) begin rise_cnt++; rise_cyc = mon_cyc; end
    if (mmcm_rst === 1'b0 && prev_rst === 1'b1) begin fall_cnt++; fall_cyc = mon_cyc; end
    prev_rst = mmcm_rst;
    if (done === 1'b1) done_cnt++;
    if (err === 1'b1) begin
      err_cnt++;
      err_cyc    = mon_cyc;
      last_code  = err_code;
      rst_at_err = mmcm_rst;
    end
    if (done === 1'b1 && err === 1'b1) both_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    act_q.delete();
    exp_q.delete();
    den_seq       = 0;
    den_cnt_mon   = 0;
    done_cnt      = 0;
    err_cnt       = 0;
    rise_cnt      = 0;
    fall_cnt      = 0;
    rise_cyc      = -1;
    fall_cyc      = -1;
    first_den_cyc = -1;
    last_den_cyc  = -1;
    err_cyc       = -1;
  endtask

  task automatic send_entry(input logic [6:0] a, input logic [15:0] m,
                            input logic [15:0] d, input logic l);
    int n;
    n = 0;
    bus.s_valid = 1'b1;
    bus.s_addr  = a;
    bus.s_mask  = m;
    bus.s_data  = d;
    bus.s_last  = l;
    while (bus.s_ready !== 1'b1 && n < 2000) begin tick(); n++; end
    check("entry_accept", 32'(bus.s_ready), 32'd1);
    tick();
    bus.s_valid = 1'b0;
  endtask

  task automatic exp_entry(input logic [6:0] a, input logic [15:0] di, input bit with_wr);
    exp_q.push_back({1'b0, a, 16'h0000});
    if (with_wr) begin
      exp_q.push_back({1'b1, a, di});
`ifdef MMCM_DRP_READBACK_EN
      exp_q.push_back({1'b0, a, 16'h0000});
`endif
    end
  endtask

  task automatic wait_fall(input int budget);
    int n;
    n = 0;
    while (fall_cnt == 0 && n < budget) begin tick(); n++; end
    check("rst_release_seen", 32'(fall_cnt > 0), 32'd1);
  endtask

  task automatic wait_err(input int budget);
    int n;
    n = 0;
    while (err_cnt == 0 && n < budget) begin tick(); n++; end
    check("err_seen", 32'(err_cnt), 32'd1);
  endtask

  task automatic compare_sb(input string name);
    check({name, "_den_count"}, 32'(act_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && act_q.size() > 0)
      check({name, "_den"}, 32'(act_q.pop_front()), 32'(exp_q.pop_front()));
  endtask

  task automatic check_all_zero(input string name);
    check(name, 32'({bus.s_ready, busy, mmcm_rst, bus.drp_en, bus.drp_we, done, err, err_code}), 32'd0);
    check({name, "_addr_di"}, 32'({bus.drp_addr, bus.drp_di}), 32'd0);
    check({name, "_state"}, 32'(state_dbg), 32'd0);
  endtask

  // One complete single-entry reconfiguration, locked rising after lock_dly cycles
  task automatic run_single(input vec_t v, input int lock_dly);
    int n;
    clear_mon();
    locked = 1'b0;
    mem[v.addr] = v.do_val;
    exp_entry(v.addr, v.exp_di, 1'b1);
    send_entry(v.addr, v.mask, v.data, 1'b1);
    wait_fall(400);
    check("rst_hold_before_den", 32'((first_den_cyc - rise_cyc) >= 4), 32'd1);
    check("rst_fall_after_last_rdy", 32'(fall_cyc - last_den_cyc), 32'd2);
    check("rst_single_pulse", 32'({rise_cnt[7:0], fall_cnt[7:0]}), 32'h0101);
    repeat (lock_dly - 1) tick();
    locked = 1'b1;
    n = 0;
    while (done !== 1'b1 && n < 20) begin tick(); n++; end
    check("done_latency", 32'(n), 32'd3);
    tick();
    check("done_once", 32'(done_cnt), 32'd1);
    check("no_err", 32'(err_cnt), 32'd0);
    check("busy_after_done", 32'({busy, state_dbg}), 32'd0);
    compare_sb("single");
    locked = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs[5];
  vec_t v;

  initial begin
    vecs[0] = '{addr: 7'h08, mask: 16'h1000, data: 16'h0041, do_val: 16'hFFFF, exp_di: 16'h1041};
    vecs[1] = '{addr: 7'h7F, mask: 16'hFFFF, data: 16'h1234, do_val: 16'hA5A5, exp_di: 16'hA5A5};
    vecs[2] = '{addr: 7'h00, mask: 16'h0000, data: 16'hBEEF, do_val: 16'h1234, exp_di: 16'hBEEF};
    vecs[3] = '{addr: 7'h15, mask: 16'hFF00, data: 16'h00CD, do_val: 16'h12AB, exp_di: 16'h12CD};
    vecs[4] = '{addr: 7'h2A, mask: 16'h0F0F, data: 16'hF0F0, do_val: 16'h5A5A, exp_di: 16'hFAFA};

    for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
    rst_n       = 1'b0;
    locked      = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_addr  = '0;
    bus.s_mask  = '0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    clear_mon();

    // Reset state
    repeat (3) tick();
    check_all_zero("reset_outputs");
    rst_n = 1'b1;
    tick();
    check("ready_after_reset", 32'({bus.s_ready, busy}), 32'h2);

    // Table: single-entry read-modify-write with locked 10 cycles after release
    for (int i = 0; i < 5; i++) run_single(vecs[i], 10);

    // Three entries, s_valid gapped by 5 cycles, last on the third
    clear_mon();
    mem[7'h10] = 16'hAB00;
    mem[7'h11] = 16'h7777;
    mem[7'h12] = 16'h3333;
    exp_entry(7'h10, 16'hAB11, 1'b1);
    exp_entry(7'h11, 16'h2222, 1'b1);
    exp_entry(7'h12, 16'h3333, 1'b1);
    send_entry(7'h10, 16'hFF00, 16'h0011, 1'b0);
    repeat (5) tick();
    send_entry(7'h11, 16'h0000, 16'h2222, 1'b0);
    repeat (5) tick();
    send_entry(7'h12, 16'hFFFF, 16'h0000, 1'b1);
    wait_fall(400);
    check("multi_rst_no_glitch", 32'({rise_cnt[7:0], fall_cnt[7:0]}), 32'h0101);
    check("multi_rst_fall_after_last_rdy", 32'(fall_cyc - last_den_cyc), 32'd2);
    check("multi_den_total", 32'(den_cnt_mon), 32'(3 * DEN_PER_ENTRY));
    repeat (2) tick();
    locked = 1'b1;
    repeat (6) tick();
    check("multi_done", 32'({done_cnt[7:0], err_cnt[7:0]}), 32'h0100);
    compare_sb("multi");
    locked = 1'b0;

    // DRDY withheld on the second entry's read: timeout, then FLUSH
    clear_mon();
    withhold_idx = DEN_PER_ENTRY;
    mem[7'h40] = 16'h0F0F;
    exp_entry(7'h40, 16'h0F0F, 1'b1);
    exp_entry(7'h41, 16'h0000, 1'b0);
    send_entry(7'h40, 16'hFFFF, 16'h0000, 1'b0);
    send_entry(7'h41, 16'h0000, 16'h1111, 1'b0);
    wait_err(400);
    check("drdy_timeout_code", 32'(last_code), 32'd1);
    check("drdy_timeout_code_held", 32'(err_code), 32'd1);
    check("drdy_timeout_rst_low", 32'(rst_at_err), 32'd0);
    check("drdy_timeout_cycles", 32'(err_cyc - last_den_cyc), 32'(DRDY_TIMEOUT + 1));
    send_entry(7'h42, 16'h0000, 16'h2222, 1'b1);
    repeat (3) tick();
    check("flush_no_more_den", 32'(den_cnt_mon), 32'(DEN_PER_ENTRY + 1));
    check("flush_back_idle", 32'({busy, state_dbg}), 32'd0);
    check("flush_no_done", 32'({done_cnt[7:0], err_cnt[7:0]}), 32'h0001);
    compare_sb("timeout");
    withhold_idx = -1;

    // Lock timeout: locked never rises
    clear_mon();
    mem[7'h20] = 16'h0000;
    exp_entry(7'h20, 16'h00F0, 1'b1);
    send_entry(7'h20, 16'h0000, 16'h00F0, 1'b1);
    wait_fall(400);
    wait_err(LOCK_TIMEOUT + 100);
    check("lock_timeout_code", 32'(last_code), 32'd2);
    check("lock_timeout_cycles", 32'(err_cyc - fall_cyc), 32'(LOCK_TIMEOUT + 1));
    tick();
    check("lock_timeout_no_done", 32'(done_cnt), 32'd0);
    check("lock_timeout_idle", 32'({busy, mmcm_rst, state_dbg}), 32'd0);
    compare_sb("locktmo");

    // Reset asserted while waiting for the write's DRDY
    clear_mon();
    withhold_idx = 1;
    send_entry(7'h30, 16'h0000, 16'h5555, 1'b1);
    begin
      int n;
      n = 0;
      while (den_cnt_mon < 2 && n < 50) begin tick(); n++; end
    end
    check("midrst_in_wr_wait", 32'(state_dbg), 32'd5);
    rst_n = 1'b0;
    tick();
    check_all_zero("midrst_outputs");
    rst_n = 1'b1;
    withhold_idx = -1;
    tick();
    v = '{addr: 7'h31, mask: 16'h00FF, data: 16'hAB00, do_val: 16'h1234, exp_di: 16'hAB34};
    run_single(v, 4);

`ifdef MMCM_DRP_READBACK_EN
    // Read-back corrupted in bit 0: verify mismatch
    clear_mon();
    corrupt = 1'b1;
    mem[7'h50] = 16'h0000;
    send_entry(7'h50, 16'h0000, 16'h0AA0, 1'b1);
    wait_err(400);
    check("readback_code", 32'(last_code), 32'd3);
    check("readback_rst_low", 32'(rst_at_err), 32'd0);
    tick();
    check("readback_idle", 32'({busy, state_dbg}), 32'd0);
    check("readback_no_done", 32'(done_cnt), 32'd0);
    corrupt = 1'b0;
`endif

    // ---------------- final report ----------------
    check("done_err_exclusive", 32'(both_cnt), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
